stdp_pair_controller: RTL and testbench

- Sequences the STDP weight update for the synapse from neuron 1 (pre) to neuron 2 (post) in the two-neuron HH/STDP core.
- Tracks spike timing with two saturating interval timers and classifies each spike pair as LTP or LTD.
- Computes a timing-dependent step and applies it to the synaptic weight register through a 2-stage capture/apply pipeline.
- Owns the weight: the HH datapath reads `weight`, and the host can overwrite it through a config write port.

---
 rtl/stdp_pair_controller_if.sv | 27 ++
 rtl/stdp_pair_controller.sv | 134 +++++++++++++
 tb/tb_stdp_pair_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/stdp_pair_controller_if.sv
// Interface between the STDP pair controller and its host/datapath.
// The controller uses the slave modport; the driving side uses the master modport.
interface stdp_pair_controller_if #(
  parameter int unsigned W_WIDTH = 8,
  parameter int unsigned T_WIDTH = 8
);
  logic               ena;
  logic               pre_spike;
  logic               post_spike;
  logic               learn_en;
  logic               cfg_we;
  logic [W_WIDTH-1:0] cfg_wdata;
  logic [W_WIDTH-1:0] weight;
  logic               ltp_pulse;
  logic               ltd_pulse;
  logic [T_WIDTH-1:0] last_dt;

  modport master (
    output ena, pre_spike, post_spike, learn_en, cfg_we, cfg_wdata,
    input  weight, ltp_pulse, ltd_pulse, last_dt
  );

  modport slave (
    input  ena, pre_spike, post_spike, learn_en, cfg_we, cfg_wdata,
    output weight, ltp_pulse, ltd_pulse, last_dt
  );
endinterface

// File: rtl/stdp_pair_controller.sv
// STDP weight update sequencer for the pre->post synapse: spike interval timers,
// LTP/LTD classification, and a capture/apply pipeline onto the owned weight register.
module stdp_pair_controller #(
  parameter int unsigned W_WIDTH    = 8,
  parameter int unsigned T_WIDTH    = 8,
  parameter int unsigned WINDOW     = 40,
  parameter int unsigned DECAY_STEP = 8,
  parameter int unsigned A_PLUS     = 16,
  parameter int unsigned A_MINUS    = 12,
  parameter int unsigned W_INIT     = 128,
  parameter int unsigned W_MIN      = 0,
  parameter int unsigned W_MAX      = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  stdp_pair_controller_if.slave bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StPend = 1'b1;

  localparam logic [T_WIDTH-1:0] WinT   = T_WIDTH'(WINDOW);
  localparam logic [W_WIDTH-1:0] WInit  = W_WIDTH'(W_INIT);
  localparam logic [W_WIDTH-1:0] WMinW  = W_WIDTH'(W_MIN);
  localparam logic [W_WIDTH-1:0] WMaxW  = W_WIDTH'(W_MAX);
  localparam logic [W_WIDTH:0]   WMinX  = (W_WIDTH+1)'(W_MIN);
  localparam logic [W_WIDTH:0]   WMaxX  = (W_WIDTH+1)'(W_MAX);

  logic [T_WIDTH-1:0] pre_timer_q, pre_timer_d;
  logic [T_WIDTH-1:0] post_timer_q, post_timer_d;
  logic [0:0]         state_q, state_d;
  logic               pend_ltp_q, pend_ltp_d;
  logic [T_WIDTH-1:0] pend_dt_q, pend_dt_d;
  logic [W_WIDTH-1:0] pend_step_q, pend_step_d;
  logic [W_WIDTH-1:0] weight_q, weight_d;
  logic               ltp_q, ltp_d;
  logic               ltd_q, ltd_d;
  logic [T_WIDTH-1:0] last_dt_q, last_dt_d;

  logic               cap_ltp, cap_ltd;
  logic [T_WIDTH-1:0] cap_dt;
  logic [W_WIDTH-1:0] cap_step;
  logic [W_WIDTH:0]   sum;
  logic [W_WIDTH:0]   diff;
  logic               lo_clip;

  always_comb begin
    cap_ltp  = bus.learn_en & bus.post_spike & ~bus.pre_spike & (pre_timer_q < WinT);
    cap_ltd  = bus.learn_en & bus.pre_spike & ~bus.post_spike & (post_timer_q < WinT);
    cap_dt   = cap_ltp ? pre_timer_q : post_timer_q;
    cap_step = cap_ltp ? W_WIDTH'(A_PLUS >> (32'(cap_dt) / DECAY_STEP))
                       : W_WIDTH'(A_MINUS >> (32'(cap_dt) / DECAY_STEP));
    // One extra bit so neither direction can wrap before clipping.
    sum      = {1'b0, weight_q} + {1'b0, pend_step_q};
    diff     = {1'b0, weight_q} - {1'b0, pend_step_q};
    lo_clip  = {1'b0, weight_q} < ({1'b0, pend_step_q} + WMinX);
  end

  always_comb begin
    pre_timer_d  = pre_timer_q;
    post_timer_d = post_timer_q;
    state_d      = state_q;
    pend_ltp_d   = pend_ltp_q;
    pend_dt_d    = pend_dt_q;
    pend_step_d  = pend_step_q;
    weight_d     = weight_q;
    last_dt_d    = last_dt_q;
    ltp_d        = 1'b0;
    ltd_d        = 1'b0;

    if (bus.ena) begin
      if (bus.pre_spike)          pre_timer_d = '0;
      else if (pre_timer_q < WinT) pre_timer_d = pre_timer_q + 1'b1;
      else                         pre_timer_d = WinT;

      if (bus.post_spike)           post_timer_d = '0;
      else if (post_timer_q < WinT) post_timer_d = post_timer_q + 1'b1;
      else                          post_timer_d = WinT;

      state_d = (cap_ltp | cap_ltd) ? StPend : StIdle;
      if (cap_ltp | cap_ltd) begin
        pend_ltp_d  = cap_ltp;
        pend_dt_d   = cap_dt;
        pend_step_d = cap_step;
      end

      // A host write wins over and drops any apply landing on the same edge.
      if (bus.cfg_we) begin
        weight_d = bus.cfg_wdata;
      end else if (state_q == StPend) begin
        last_dt_d = pend_dt_q;
        if (pend_ltp_q) begin
          weight_d = (sum > WMaxX) ? WMaxW : sum[W_WIDTH-1:0];
          ltp_d    = 1'b1;
        end else begin
          weight_d = lo_clip ? WMinW : diff[W_WIDTH-1:0];
          ltd_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_timer_q  <= WinT;
      post_timer_q <= WinT;
      state_q      <= StIdle;
      pend_ltp_q   <= 1'b0;
      pend_dt_q    <= '0;
      pend_step_q  <= '0;
      weight_q     <= WInit;
      ltp_q        <= 1'b0;
      ltd_q        <= 1'b0;
      last_dt_q    <= '0;
    end else begin
      pre_timer_q  <= pre_timer_d;
      post_timer_q <= post_timer_d;
      state_q      <= state_d;
      pend_ltp_q   <= pend_ltp_d;
      pend_dt_q    <= pend_dt_d;
      pend_step_q  <= pend_step_d;
      weight_q     <= weight_d;
      ltp_q        <= ltp_d;
      ltd_q        <= ltd_d;
      last_dt_q    <= last_dt_d;
    end
  end

  assign bus.weight    = weight_q;
  assign bus.ltp_pulse = ltp_q;
  assign bus.ltd_pulse = ltd_q;
  assign bus.last_dt   = last_dt_q;

endmodule

// File: tb/tb_stdp_pair_controller.sv
// Directed-vector bench: stimulus pushes expected updates, a monitor pops them on each pulse.
module tb_stdp_pair_controller;

  typedef struct packed {
    logic       ltp;
    logic [7:0] w;
    logic [7:0] dt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  stdp_pair_controller_if #(.W_WIDTH(8), .T_WIDTH(8)) bus ();

  stdp_pair_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.ltp_pulse || bus.ltd_pulse)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got ltp=%0d ltd=%0d weight=%0d expected no pulse",
                 bus.ltp_pulse, bus.ltd_pulse, bus.weight);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, bus.ltp_pulse, bus.ltd_pulse}, e.ltp ? 2 : 1);
        chk("pulse_weight", int'(bus.weight), int'(e.w));
        chk("pulse_last_dt", int'(bus.last_dt), int'(e.dt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pre();
    bus.pre_spike = 1'b1;
    tick();
    bus.pre_spike = 1'b0;
  endtask

  task automatic post();
    bus.post_spike = 1'b1;
    tick();
    bus.post_spike = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] v);
    bus.cfg_we    = 1'b1;
    bus.cfg_wdata = v;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic expect_upd(input logic ltp, input logic [7:0] w, input logic [7:0] dt);
    exp_t e;
    e.ltp = ltp;
    e.w   = w;
    e.dt  = dt;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.ena        = 1'b1;
    bus.pre_spike  = 1'b0;
    bus.post_spike = 1'b0;
    bus.learn_en   = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    idle(100);
    chk("reset_weight", int'(bus.weight), 128);
    chk("reset_last_dt", int'(bus.last_dt), 0);
    chk("reset_pulses", int'({bus.ltp_pulse, bus.ltd_pulse}), 0);
    chk("reset_pre_timer", int'(dut.pre_timer_q), 40);
    chk("reset_post_timer", int'(dut.post_timer_q), 40);

    // LTP dt=4: 128+16
    pre();
    idle(4);
    expect_upd(1'b1, 8'd144, 8'd4);
    post();
    idle(60);

    // LTD dt=19: 12>>2=3
    post();
    idle(19);
    expect_upd(1'b0, 8'd141, 8'd19);
    pre();
    idle(60);

    // Coincident spikes, then a pre with the post timer saturated.
    bus.pre_spike  = 1'b1;
    bus.post_spike = 1'b1;
    tick();
    bus.pre_spike  = 1'b0;
    bus.post_spike = 1'b0;
    idle(49);
    pre();
    idle(60);
    chk("no_update_weight", int'(bus.weight), 141);

    // Clipping at both ends.
    cfg(8'd250);
    chk("cfg_250", int'(bus.weight), 250);
    pre();
    expect_upd(1'b1, 8'd255, 8'd0);
    post();
    idle(60);
    cfg(8'd5);
    chk("cfg_5", int'(bus.weight), 5);
    post();
    expect_upd(1'b0, 8'd0, 8'd0);
    pre();
    idle(60);

    // Host write on the apply edge wins; no pulse.
    pre();
    post();
    cfg(8'd77);
    chk("cfg_over_apply", int'(bus.weight), 77);
    idle(60);

    // ena=0: spikes and cfg ignored.
    bus.ena = 1'b0;
    pre();
    post();
    cfg(8'd9);
    idle(3);
    chk("ena_off_weight", int'(bus.weight), 77);
    bus.ena = 1'b1;
    idle(60);
    chk("ena_on_weight", int'(bus.weight), 77);

    // learn_en=0 blocks capture but not an already pending apply.
    bus.learn_en = 1'b0;
    pre();
    post();
    idle(3);
    chk("learn_off_weight", int'(bus.weight), 77);
    bus.learn_en = 1'b1;
    idle(60);
    pre();
    expect_upd(1'b1, 8'd93, 8'd0);
    post();
    bus.learn_en = 1'b0;
    idle(3);
    bus.learn_en = 1'b1;
    idle(60);

    // Back-to-back capture/apply overlap.
    pre();
    expect_upd(1'b1, 8'd109, 8'd0);
    post();
    expect_upd(1'b0, 8'd97, 8'd0);
    pre();
    idle(60);

    // Decay boundaries: dt=8 halves, dt=39 -> 1, dt=40 no update.
    pre();
    idle(8);
    expect_upd(1'b1, 8'd105, 8'd8);
    post();
    idle(60);
    pre();
    idle(39);
    expect_upd(1'b1, 8'd106, 8'd39);
    post();
    idle(60);
    pre();
    idle(40);
    post();
    idle(60);
    chk("window_edge_weight", int'(bus.weight), 106);
    chk("mid_drained", sb.size(), 0);

    // Reset with an update pending.
    pre();
    post();
    rst_n = 1'b0;
    #1;
    chk("rst_weight", int'(bus.weight), 128);
    chk("rst_last_dt", int'(bus.last_dt), 0);
    chk("rst_pulses", int'({bus.ltp_pulse, bus.ltd_pulse}), 0);
    idle(2);
    rst_n = 1'b1;
    idle(10);
    chk("post_rst_weight", int'(bus.weight), 128);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
